// File: rtl/logic_unit_pkg.sv
// Shared types for the slice-serial logic unit: opcode and FSM state encodings.
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OpAnd   = 3'b000,
        OpOr    = 3'b001,
        OpXor   = 3'b010,
        OpNand  = 3'b011,
        OpNor   = 3'b100,
        OpXnor  = 3'b101,
        OpNotA  = 3'b110,
        OpPassB = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_t;

    // Slice index width; a single-slice configuration still gets one bit.
    function automatic int unsigned idx_width(input int unsigned ns);
        return (ns > 1) ? $clog2(ns) : 1;
    endfunction

endpackage

// File: rtl/logic_unit_seq_if.sv
// Request/response bundle of the logic unit: operand handshake in, result handshake out.
interface logic_unit_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             acc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             ones;
    logic             msb;

    modport master (
        output in_valid, op, acc, a, b, out_ready,
        input  in_ready, out_valid, y, zero, ones, msb
    );

    modport slave (
        input  in_valid, op, acc, a, b, out_ready,
        output in_ready, out_valid, y, zero, ones, msb
    );
endinterface

// File: rtl/logic_slice.sv
// Combinational bitwise operator over one SLICE-bit chunk of the operands.
module logic_slice
    import logic_unit_pkg::*;
#(
    parameter int unsigned SLICE = 4
) (
    input  op_t              op,
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    output logic [SLICE-1:0] y_s
);

    always_comb begin
        y_s = '0;
        unique case (op)
            OpAnd:   y_s = a_s & b_s;
            OpOr:    y_s = a_s | b_s;
            OpXor:   y_s = a_s ^ b_s;
            OpNand:  y_s = ~(a_s & b_s);
            OpNor:   y_s = ~(a_s | b_s);
            OpXnor:  y_s = ~(a_s ^ b_s);
            OpNotA:  y_s = ~a_s;
            OpPassB: y_s = b_s;
        endcase
    end

endmodule

// File: rtl/logic_unit_seq.sv
// Slice-serial bitwise logic unit: latches operands, computes SLICE bits per cycle,
// then commits the result and its flags together on the BUSY->DONE edge.
module logic_unit_seq
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    logic_unit_seq_if.slave bus
);

    localparam int unsigned NS   = WIDTH / SLICE;
    localparam int unsigned IdxW = idx_width(NS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NS - 1);

    if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
        $error("logic_unit_seq: SLICE must be nonzero and divide WIDTH");
    end

    state_t           r_state;
    state_t           w_state_next;
    logic [IdxW-1:0]  r_idx;
    op_t              r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_y;
    logic             r_zero;
    logic             r_ones;
    logic             r_msb;

    logic             w_accept;
    logic             w_last;
    logic [SLICE-1:0] w_a_s;
    logic [SLICE-1:0] w_b_s;
    logic [SLICE-1:0] w_y_s;
    logic [WIDTH-1:0] w_work_next;

    assign w_accept = (r_state == StIdle) && bus.in_valid;
    assign w_last   = (r_state == StBusy) && (r_idx == LastIdx);

    assign w_a_s = r_a[r_idx*SLICE +: SLICE];
    assign w_b_s = r_b[r_idx*SLICE +: SLICE];

    logic_slice #(
        .SLICE(SLICE)
    ) u_slice (
        .op (r_op),
        .a_s(w_a_s),
        .b_s(w_b_s),
        .y_s(w_y_s)
    );

    // Work register with the current slice merged in, so the final slice lands in y directly.
    always_comb begin
        w_work_next = r_work;
        w_work_next[r_idx*SLICE +: SLICE] = w_y_s;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (bus.in_valid) w_state_next = StBusy;
            StBusy:  if (r_idx == LastIdx) w_state_next = StDone;
            StDone:  if (bus.out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_op   <= OpAnd;
            r_a    <= '0;
            r_b    <= '0;
            r_work <= '0;
            r_y    <= '0;
            r_zero <= 1'b1;
            r_ones <= 1'b0;
            r_msb  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= op_t'(bus.op);
                r_a   <= bus.acc ? r_y : bus.a;
                r_b   <= bus.b;
                r_idx <= '0;
            end
            if (r_state == StBusy) begin
                r_work <= w_work_next;
                if (w_last) begin
                    r_y    <= w_work_next;
                    r_zero <= (w_work_next == '0);
                    r_ones <= &w_work_next;
                    r_msb  <= w_work_next[WIDTH-1];
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out_valid = (r_state == StDone);
    assign bus.y         = r_y;
    assign bus.zero      = r_zero;
    assign bus.ones      = r_ones;
    assign bus.msb       = r_msb;

endmodule

// File: doc/logic_unit_seq.md
# logic_unit_seq

Parametrised, slice-serial bitwise logic unit for the lab ALU datapath. Accepts two WIDTH-bit operands and a 3-bit opcode over a valid/ready handshake. Computes the result SLICE bits per clock and presents it with zero/all-ones/MSB flags on an output valid/ready handshake. An accumulate mode chains operations on the previous result, so multi-operand logic reductions need no external register.

## Interface
- WIDTH, 16, operand/result width in bits; WIDTH ≥ 1.
- SLICE, 4, bits processed per cycle; must divide WIDTH exactly (elaboration error otherwise).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- op  in  3  operation select.
- acc  in  1  1: operand A is the committed result y; 0: operand A is a.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result.
- y  out  WIDTH  committed result.
- zero  out  1  y == 0.
- ones  out  1  y == all ones.
- msb  out  1  y[WIDTH-1].

## Operation
- Op encoding: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT A, 111 PASS B.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid: latch op, B, and A (y if acc=1, else a). Clear slice index; go to BUSY.
- BUSY: each cycle, compute slice idx (bits idx*SLICE .. idx*SLICE+SLICE-1) into a work register; idx++.
- BUSY exit: after slice NS-1, where NS=WIDTH/SLICE, copy the work register to y and register the flags in the same edge; go to DONE.
- DONE: out_valid=1. Hold until out_ready=1, then go to IDLE.
- in_ready=1 only in IDLE. in_valid in BUSY/DONE is ignored, not queued.
- y and the flags change only on BUSY→DONE or reset. During BUSY they hold the previous result.
- a, b, op and acc are sampled only at accept; later changes have no effect.
- Flags derive from the new y value and are registered with it, never combinational from a/b.
- Reset (rst_n=0 at an edge), in any state including mid-BUSY: state=IDLE, y=0, work=0, idx=0, zero=1, ones=0, msb=0, out_valid=0, in_ready=1. Aborted operations produce no out_valid.

## Timing
- Accept at edge E0: slices computed at edges E1..ENS. out_valid is high in the cycle after edge ENS, so latency is NS cycles (4 at defaults; 1 when SLICE=WIDTH).
- DONE with out_ready=1 at edge Ed: IDLE after Ed, so in_ready is high the following cycle. Minimum request period is NS+2 cycles.
- out_valid is held with y stable for as many cycles as out_ready stays low.
- idx width is clog2(NS), minimum 1 bit. idx is not wrapped: it exits at NS-1.

## Structure
- Package logic_unit_pkg: op_t enum (the 8 encodings) and state_t enum (IDLE, BUSY, DONE).
- Sub-module logic_slice: combinational, parameter SLICE, ports (op, a_s, b_s, y_s). Instantiated once; the slice is selected by idx through an indexed part-select.
- The top level holds the FSM, operand/work/result registers and the flags.

## Test plan
- Reset: hold rst_n=0 for 2 cycles → y=0x0000, zero=1, ones=0, msb=0, in_ready=1, out_valid=0.
- OR: a=0x00F0, b=0x0F0F, op=001, acc=0 (defaults) → out_valid exactly 4 cycles after accept; y=0x0FFF, zero=0, ones=0, msb=0.
- Accumulate chain from y=0x0FFF:
  - op=010, acc=1, b=0xFFFF → y=0xF000, msb=1.
  - op=000, acc=1, b=0x0000 → y=0x0000, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 → y and out_valid stable, in_ready=0, no second accept. Raise out_ready → in_ready=1 the next cycle.
- Reset mid-operation: assert rst_n=0 after 2 BUSY cycles → out_valid never rises, y=0x0000, zero=1, state IDLE.
- Operand isolation and remaining ops:
  - Change a during BUSY: result uses the latched values.
  - NAND 0xFFFF,0xFFFF → 0x0000, zero=1.
  - NOT A with a=0x0000 → 0xFFFF, ones=1.
  - PASS B with b=0x8001 → msb=1.
  - Repeat with WIDTH=8, SLICE=8 → latency 1.
